// File: rtl/uart_rx_frame_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // 100 MHz clock, matches the system transmitter's bit period
    localparam int UART_CLKS_PER_BIT = 10418;
    // Idle bit-times after which a partially received frame is dropped
    localparam int UART_TIMEOUT_BITS = 20;

endpackage

// File: rtl/uart_rx_frame_sampler.sv
// Line front end: 2-FF synchronizer, start-edge detect and bit sampler.
// With UART_RX_MAJORITY_EN defined, sample_bit is the 2-of-3 vote of the
// synchronized line over three consecutive clocks, centred one clock back.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rxd_i,
    output logic rxd_sync,
    output logic start_edge,
    output logic sample_bit
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    // Synchronizer plus one history flop for edge detection; idle level is 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= rxd_i;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rxd_sync   = sync2_reg;
    assign start_edge = prev_reg & ~sync2_reg;

`ifdef UART_RX_MAJORITY_EN
    logic prev2_reg;

    // Second history flop, only needed for the three-point vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev2_reg <= 1'b1;
        end else begin
            prev2_reg <= prev_reg;
        end
    end

    assign sample_bit = (sync2_reg & prev_reg) | (sync2_reg & prev2_reg) | (prev_reg & prev2_reg);
`else
    assign sample_bit = sync2_reg;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver that gathers CHAR_NR bytes into one parallel frame,
// first byte in the top bits. Optional macro UART_RX_MAJORITY_EN selects
// 3-point majority sampling (all pulses then move one clock later).
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CHAR_NR      = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int TIMEOUT_BITS = UART_TIMEOUT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd_i,
    input  logic                 clr_i,
    output logic [7:0]           char_o,
    output logic                 char_valid_o,
    output logic [CHAR_NR*8-1:0] char_array_o,
    output logic                 char_array_valid_o,
    output logic                 busy_o,
    output logic                 frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
    localparam int IW = (CHAR_NR > 1) ? $clog2(CHAR_NR) : 1;
`ifdef UART_RX_MAJORITY_EN
    // One extra clock so the vote window is centred on the nominal point
    localparam int START_WAIT = CLKS_PER_BIT / 2;
`else
    localparam int START_WAIT = CLKS_PER_BIT / 2 - 1;
`endif
    localparam logic [CW-1:0] START_LOAD = CW'(START_WAIT);
    localparam logic [CW-1:0] BIT_LOAD   = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_BITS * CLKS_PER_BIT);
    localparam logic [IW-1:0] IDX_LAST   = IW'(CHAR_NR - 1);

    logic rxd_sync;
    logic start_edge;
    logic sample_bit;

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rxd_i      (rxd_i),
        .rxd_sync   (rxd_sync),
        .start_edge (start_edge),
        .sample_bit (sample_bit)
    );

    rx_state_t            state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2:0]           bits_reg, bits_next;
    logic [7:0]           data_reg, data_next;
    logic [IW-1:0]        idx_reg, idx_next;
    logic [TW-1:0]        tmo_reg, tmo_next;
    logic [7:0]           char_reg, char_next;
    logic [CHAR_NR*8-1:0] array_reg, array_next;
    logic                 cv_reg, cv_next;
    logic                 av_reg, av_next;
    logic                 fe_reg, fe_next;
    logic                 byte_ok;
    logic [CHAR_NR*8-1:0] frame_next;

    // Next-state, counters and output pulses; clear overrides everything
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bits_next  = bits_reg;
        data_next  = data_reg;
        idx_next   = idx_reg;
        tmo_next   = tmo_reg;
        char_next  = char_reg;
        array_next = array_reg;
        cv_next    = 1'b0;
        av_next    = 1'b0;
        fe_next    = 1'b0;
        byte_ok    = 1'b0;
        if (clr_i) begin
            state_next = IDLE;
            cnt_next   = '0;
            bits_next  = '0;
            idx_next   = '0;
            tmo_next   = '0;
            char_next  = '0;
            array_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // start_edge already implies a low line; the check keeps the qualifier explicit
                    if (start_edge && !rxd_sync) begin
                        state_next = START;
                        cnt_next   = START_LOAD;
                        tmo_next   = '0;
                    end else if (idx_reg != '0) begin
                        if (tmo_reg == TMO_LIMIT) begin
                            idx_next = '0;
                            tmo_next = '0;
                        end else begin
                            tmo_next = tmo_reg + TW'(1);
                        end
                    end else begin
                        tmo_next = '0;
                    end
                end
                START: begin
                    if (cnt_reg == '0) begin
                        if (sample_bit) begin
                            state_next = IDLE;      // false start
                        end else begin
                            state_next = DATA;
                            cnt_next   = BIT_LOAD;
                            bits_next  = '0;
                        end
                    end else begin
                        cnt_next = cnt_reg - CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == '0) begin
                        data_next = {sample_bit, data_reg[7:1]};
                        cnt_next  = BIT_LOAD;
                        if (bits_reg == 3'd7) begin
                            state_next = STOP;
                        end else begin
                            bits_next = bits_reg + 3'd1;
                        end
                    end else begin
                        cnt_next = cnt_reg - CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_reg == '0) begin
                        state_next = IDLE;
                        if (sample_bit) begin
                            byte_ok   = 1'b1;
                            cv_next   = 1'b1;
                            char_next = data_reg;
                            if (idx_reg == IDX_LAST) begin
                                av_next    = 1'b1;
                                array_next = frame_next;
                                idx_next   = '0;
                            end else begin
                                idx_next = idx_reg + IW'(1);
                            end
                        end else begin
                            fe_next  = 1'b1;
                            idx_next = '0;
                        end
                    end else begin
                        cnt_next = cnt_reg - CW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bits_reg  <= '0;
            data_reg  <= '0;
            idx_reg   <= '0;
            tmo_reg   <= '0;
            char_reg  <= '0;
            array_reg <= '0;
            cv_reg    <= 1'b0;
            av_reg    <= 1'b0;
            fe_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bits_reg  <= bits_next;
            data_reg  <= data_next;
            idx_reg   <= idx_next;
            tmo_reg   <= tmo_next;
            char_reg  <= char_next;
            array_reg <= array_next;
            cv_reg    <= cv_next;
            av_reg    <= av_next;
            fe_reg    <= fe_next;
        end
    end

    // Byte slots of the partial frame; the last slot comes straight from data_reg
    genvar gi;
    generate
        for (gi = 0; gi < CHAR_NR; gi++) begin : g_slot
            if (gi == CHAR_NR - 1) begin : g_last
                assign frame_next[(CHAR_NR-1-gi)*8 +: 8] = data_reg;
            end else begin : g_mid
                logic [7:0] slot_reg;
                // Capture the accepted byte into the slot its index points at
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        slot_reg <= '0;
                    end else if (byte_ok && idx_reg == IW'(gi)) begin
                        slot_reg <= data_reg;
                    end
                end
                assign frame_next[(CHAR_NR-1-gi)*8 +: 8] = slot_reg;
            end
        end
    endgenerate

    assign char_o             = char_reg;
    assign char_valid_o       = cv_reg;
    assign char_array_o       = array_reg;
    assign char_array_valid_o = av_reg;
    assign frame_err_o        = fe_reg;
    assign busy_o             = (state_reg != IDLE) || (idx_reg != '0);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: drives 8N1 bytes, predicts pulses and frames
// from the line-level rules and checks every cycle.
module tb_uart_rx_frame;

    localparam int C     = 16;
    localparam int H     = C / 2;
    localparam int NR    = 2;
    localparam int TB    = 4;
    localparam int LIMIT = TB * C;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rxd = 1'b1;
    logic            clr = 1'b0;
    logic [7:0]      char_o;
    logic            char_valid_o;
    logic [NR*8-1:0] char_array_o;
    logic            char_array_valid_o;
    logic            busy_o;
    logic            frame_err_o;

    uart_rx_frame #(
        .CHAR_NR      (NR),
        .CLKS_PER_BIT (C),
        .TIMEOUT_BITS (TB)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rxd_i              (rxd),
        .clr_i              (clr),
        .char_o             (char_o),
        .char_valid_o       (char_valid_o),
        .char_array_o       (char_array_o),
        .char_array_valid_o (char_array_valid_o),
        .busy_o             (busy_o),
        .frame_err_o        (frame_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int              at;
        bit              is_clr;
        bit              cv;
        bit              fe;
        bit              av;
        logic [7:0]      ch;
        logic [NR*8-1:0] arr;
    } ev_t;

    ev_t evq[$];

    // Sender-side frame model
    int         m_idx = 0;
    int         m_last_acc = 0;
    logic [7:0] m_part [NR];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one byte; optional bad stop (held low extra clocks), clear mid-byte, or spikes
    task automatic send_byte(input logic [7:0] b, input bit good_stop, input int clr_bit,
                             input int low_hold, input bit spike);
        int n;
        int t0;
        ev_t ev;
        n  = cyc;
        t0 = n + 3;
        $display("tx byte %02h stop=%0d clr_bit=%0d at cycle %0d", b, good_stop, clr_bit, n);
        if (clr_bit < 0) begin
            if (m_idx > 0 && (t0 - m_last_acc) > LIMIT) m_idx = 0;
            ev.at = t0 + H + 9 * C + LAT;
            ev.is_clr = 1'b0;
            ev.cv = good_stop;
            ev.fe = !good_stop;
            ev.av = 1'b0;
            ev.ch = b;
            ev.arr = '0;
            if (good_stop) begin
                m_part[m_idx] = b;
                if (m_idx == NR - 1) begin
                    ev.av = 1'b1;
                    for (int k = 0; k < NR; k++) ev.arr[(NR-1-k)*8 +: 8] = m_part[k];
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
                m_last_acc = ev.at;
            end else begin
                m_idx = 0;
            end
            evq.push_back(ev);
        end
        rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (clr_bit == i) begin
                tick(H);
                clr = 1'b1;
                ev.at = cyc + 1;
                ev.is_clr = 1'b1;
                ev.cv = 1'b0;
                ev.fe = 1'b0;
                ev.av = 1'b0;
                ev.ch = '0;
                ev.arr = '0;
                evq.push_back(ev);
                m_idx = 0;
                tick(1);
                clr = 1'b0;
                rxd = 1'b1;
                tick(2 * C);
                return;
            end
            if (spike) begin
                tick(H);
                rxd = ~b[i];
                tick(1);
                rxd = b[i];
                tick(C - H - 1);
            end else begin
                tick(C);
            end
        end
        rxd = good_stop;
        tick(C + (good_stop ? 0 : low_hold));
        rxd = 1'b1;
    endtask

    // Per-cycle compare against the event-driven model
    logic [7:0]      m_char = '0;
    logic [NR*8-1:0] m_arr  = '0;
    logic            prev_busy = 1'b0;
    bit              e_cv, e_fe, e_av;
    ev_t             cur;

    always @(negedge clk) begin
        e_cv = 1'b0;
        e_fe = 1'b0;
        e_av = 1'b0;
        if (evq.size() > 0 && evq[0].at <= cyc) begin
            cur = evq.pop_front();
            if (cur.is_clr) begin
                m_char = '0;
                m_arr  = '0;
            end else begin
                e_cv = cur.cv;
                e_fe = cur.fe;
                e_av = cur.av;
                if (cur.cv) m_char = cur.ch;
                if (cur.av) m_arr = cur.arr;
            end
            if (cur.av) begin
                chk("busy_low_at_frame", busy_o, 0);
                chk("busy_high_before_frame", prev_busy, 1);
            end
        end
        chk("char_valid", char_valid_o, e_cv);
        chk("frame_err", frame_err_o, e_fe);
        chk("array_valid", char_array_valid_o, e_av);
        chk("char", char_o, m_char);
        chk("char_array", char_array_o, m_arr);
        prev_busy = busy_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    int bc;
    int gap;
    bit good;

    initial begin
        tick(5);
        chk("reset_busy", busy_o, 0);
        chk("reset_char", char_o, 0);
        rst = 1'b0;
        tick(10);

        // Back-to-back frame
        send_byte(8'h41, 1'b1, -1, 0, 1'b0);
        send_byte(8'h5A, 1'b1, -1, 0, 1'b0);
        tick(20);
        chk("lit_frame_415a", char_array_o, 32'h415A);
        chk("lit_char_5a", char_o, 32'h5A);

        // Short low glitch: false start only
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        bc = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_o) bc++;
        end
        #1;
        chk("glitch_busy_nonzero", (bc > 0), 1);
        chk("glitch_busy_le12", (bc <= 12), 1);
        chk("glitch_busy_low_after", busy_o, 0);

        // Bad stop followed by a held-low break, then a clean frame
        send_byte(8'h33, 1'b0, -1, 100, 1'b0);
        tick(2 * C);
        send_byte(8'h12, 1'b1, -1, 0, 1'b0);
        send_byte(8'h34, 1'b1, -1, 0, 1'b0);
        tick(20);
        chk("lit_frame_1234", char_array_o, 32'h1234);

        // Partial frame dropped by the idle timeout
        send_byte(8'hAA, 1'b1, -1, 0, 1'b0);
        tick(5 * C);
        chk("timeout_busy_low", busy_o, 0);
        send_byte(8'h55, 1'b1, -1, 0, 1'b0);
        send_byte(8'h66, 1'b1, -1, 0, 1'b0);
        tick(20);
        chk("lit_frame_5566", char_array_o, 32'h5566);

        // Clear during data bit 3 aborts the byte
        send_byte(8'h0F, 1'b1, 3, 0, 1'b0);
        chk("lit_after_clr_char", char_o, 0);
        chk("lit_after_clr_array", char_array_o, 0);
        send_byte(8'h01, 1'b1, -1, 0, 1'b0);
        chk("lit_first_after_clr", char_o, 32'h01);
        send_byte(8'h02, 1'b1, -1, 0, 1'b0);
        tick(20);
        chk("lit_frame_0102", char_array_o, 32'h0102);

`ifdef UART_RX_MAJORITY_EN
        // Single-clock spikes at every data sample point are voted out
        send_byte(8'hC3, 1'b1, -1, 0, 1'b1);
        tick(20);
        chk("lit_majority_c3", char_o, 32'hC3);
`endif

        // Randomized traffic: short or long gaps, occasional bad stop bits
        for (int t = 0; t < 40; t++) begin
            good = ($urandom_range(0, 7) != 0);
            send_byte(8'($urandom), good, -1, $urandom_range(0, 30), 1'b0);
            if (!good) begin
                gap = 2 * C + $urandom_range(0, C);
            end else begin
                case ($urandom_range(0, 2))
                    0:       gap = 0;
                    1:       gap = $urandom_range(1, 2 * C);
                    default: gap = $urandom_range(5 * C, 6 * C);
                endcase
            end
            tick(gap);
        end

        tick(200);
        chk("events_drained", evq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
